load_store_unit: RTL

Data-side load/store unit sitting between the execute stage and data port B of the fake memory. Accepts one load or store per handshake, drives the memory's word-only port (mem_op / mem_addr / mem_din), extracts and sign/zero-extends byte and halfword loads, and implements byte/halfword stores as read-modify-write because the memory has no byte enables. Returns one single-cycle response per request, with an error flag for misaligned, illegal or timed-out accesses.

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-side load/store unit in front of the word-only port B of the fake memory.
// Extends sub-word loads and performs byte/halfword stores as read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [1:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_valid
);

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;
  localparam logic [3:0] TIMEOUT       = 4'd15;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_WAIT, WR, ERR_RSP} state_t;

  state_t      state, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  mem_op_d;
  logic [31:0] mem_addr_d, mem_din_d;
  logic        resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic [4:0]  resp_rd_d;

  logic        req_illegal, req_misaligned, req_bad;
  logic [31:0] lane_word, load_data;
  logic [31:0] size_mask, lane_mask, lane_data, merged_word;

  assign req_ready = (state == IDLE);

  assign req_illegal = req_store ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                                 : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_bad = req_illegal || req_misaligned;

  // Byte k of the word sits at bits [8k+7:8k]; shift the addressed lane down to bit 0.
  assign lane_word = mem_dout >> {lane_q, 3'b000};

  always_comb begin
    case (funct3_q)
      F3_B:    load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      F3_H:    load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      F3_BU:   load_data = {24'h0, lane_word[7:0]};
      F3_HU:   load_data = {16'h0, lane_word[15:0]};
      default: load_data = mem_dout;
    endcase
  end

  assign size_mask   = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
  assign lane_mask   = size_mask << {lane_q, 3'b000};
  assign lane_data   = (wdata_q & size_mask) << {lane_q, 3'b000};
  assign merged_word = (mem_dout & ~lane_mask) | lane_data;

  always_comb begin
    // NOTE: every value driven here gets a default first, so no path can infer a latch.
    state_d      = state;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    mem_op_d     = MEM_DISABLE;
    mem_addr_d   = mem_addr;
    mem_din_d    = mem_din;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    resp_rd_d    = resp_rd;

    case (state)
      IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          cnt_d    = 4'd0;
          if (req_bad) begin
            // Error response leaves on the acceptance edge; ERR_RSP is only the turnaround.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rd_d    = req_rd;
            state_d      = ERR_RSP;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (!req_store) begin
              mem_op_d = req_funct3[2] ? MEM_READ_ZEXT : MEM_READ_SEXT;
              state_d  = RD_WAIT;
            end else if (req_funct3 == F3_W) begin
              mem_op_d  = MEM_WRITE;
              mem_din_d = req_wdata;
              state_d   = WR;
            end else begin
              mem_op_d = MEM_READ_ZEXT;
              state_d  = RMW_WAIT;
            end
          end
        end
      end

      RD_WAIT, RMW_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (mem_valid) begin
          if (state == RD_WAIT) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
            resp_rd_d    = rd_q;
            state_d      = IDLE;
          end else begin
            mem_din_d = merged_word;
            mem_op_d  = MEM_WRITE;
            state_d   = WR;
          end
        end else if (cnt_q == TIMEOUT) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rd_d    = rd_q;
          state_d      = IDLE;
        end
      end

      WR: begin
        resp_valid_d = 1'b1;
        resp_rd_d    = rd_q;
        state_d      = IDLE;
      end

      ERR_RSP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      wdata_q    <= 32'h0;
      rd_q       <= 5'd0;
      cnt_q      <= 4'd0;
      mem_op     <= MEM_DISABLE;
      mem_addr   <= 32'h0;
      mem_din    <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      resp_rd    <= 5'd0;
    end else begin
      state      <= state_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      mem_op     <= mem_op_d;
      mem_addr   <= mem_addr_d;
      mem_din    <= mem_din_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      resp_rd    <= resp_rd_d;
    end
  end

endmodule
